sram_fifo_ctrl: RTL and testbench
=================================

SRAM_FIFO_CTRL -- requirements
Module: sram_fifo_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 8, data width in bits.
REQ-002 SHALL have parameter DEPTH, default 10, SRAM entries; any value >=2, power of two not required.
REQ-003 SHALL have parameter RD_LAT, default 2, SRAM read latency in cycles, >=1.
REQ-004 SHALL have port clk_i  input  1  sole clock; all logic on rising edge.
REQ-005 SHALL have port rst_ni  input  1  asynchronous active-low reset.
REQ-006 SHALL have ports up_valid_i input 1, up_ready_o output 1, up_data_i input WIDTH: upstream valid/ready.
REQ-007 SHALL have ports down_valid_o output 1, down_ready_i input 1, down_data_o output WIDTH: downstream valid/ready.
REQ-008 SHALL have ports sram_wr_en_o output 1, sram_wr_addr_o output $clog2(DEPTH), sram_wr_data_o output WIDTH.
REQ-009 SHALL have ports sram_rd_en_o output 1, sram_rd_addr_o output $clog2(DEPTH), sram_rd_data_i input WIDTH (valid exactly RD_LAT cycles after sram_rd_en_o).
REQ-010 SHALL have ports empty_o output 1, full_o output 1, count_o output $clog2(DEPTH+RD_LAT+2): total entries held.

Function
REQ-011 SHALL define up handshake = up_valid_i && up_ready_o and down handshake = down_valid_o && down_ready_i; data order preserved end to end.
REQ-012 SHALL drive up_ready_o = (SRAM occupancy < DEPTH), independent of down_ready_i; full_o = ~up_ready_o.
REQ-013 SHALL, on up handshake, assert sram_wr_en_o same cycle with sram_wr_addr_o = wr_ptr, sram_wr_data_o = up_data_i; wr_ptr increments, wrapping DEPTH-1 -> 0.
REQ-014 SHALL hold an output buffer (OBUF) of RD_LAT+1 entries; credits = RD_LAT+1 - (OBUF occupancy + in-flight reads).
REQ-015 SHALL assert sram_rd_en_o when SRAM occupancy > 0 and credits > 0, address rd_ptr; rd_ptr increments, wrapping DEPTH-1 -> 0.
REQ-016 SHALL never read an entry in the cycle it is written; an entry written in cycle t is readable from cycle t+1.
REQ-017 SHALL track in-flight reads in an RD_LAT-stage valid shift register and push sram_rd_data_i into OBUF when the last stage is set.
REQ-018 SHALL drive down_valid_o = OBUF non-empty, down_data_o = OBUF head; empty_o = (count_o == 0).
REQ-019 SHALL sustain one transfer per cycle in steady state with down_ready_i held high.
REQ-020 SHALL, without bypass, give latency: handshake cycle t -> sram_rd_en_o cycle t+1 -> down_valid_o cycle t+2+RD_LAT (SRAM initially empty).
REQ-021 SHALL allow simultaneous up and down handshakes, including at full and at single-entry occupancy; count_o unchanged then.
REQ-022 SHALL keep SRAM occupancy and count_o exact through pointer wrap.

Reset
REQ-023 SHALL, on rst_ni low, asynchronously clear pointers, occupancy, in-flight shift register and OBUF: down_valid_o=0, empty_o=1, full_o=0, up_ready_o=1, count_o=0, sram_wr_en_o=0, sram_rd_en_o=0.
REQ-024 SHALL discard SRAM read data returning after a reset asserted mid-read.

Configuration
REQ-025 SHALL, with SRAM_FIFO_BYPASS_EN defined, write up_data_i directly into OBUF (no SRAM write) when SRAM occupancy = 0, in-flight = 0 and credits > 0, giving down_valid_o at t+1.
REQ-026 SHALL, without SRAM_FIFO_BYPASS_EN, route every entry through SRAM per REQ-020.

Structure
REQ-027 SHALL place ptr-width/count-width helper functions and the OBUF depth constant in package sram_fifo_pkg.
REQ-028 SHALL implement OBUF as sub-module fifo_flop (flop-based FIFO, parameters WIDTH, DEPTH).

Verification
REQ-029 SHALL cover: RD_LAT=2, no bypass, one write 8'hA5 at cycle t -> down_valid_o at t+4, data 8'hA5.
REQ-030 SHALL cover: down_ready_i=0, 13 writes -> up_ready_o=0 after 10 (DEPTH), count_o=13 after OBUF fills, full_o=1; then drain 13 in order.
REQ-031 SHALL cover: continuous valid/ready for 50 items -> one output per cycle after initial latency, sequence 0..49 in order, pointers wrap.
REQ-032 SHALL cover: bypass build, empty FIFO, write 8'h3C at t -> down_valid_o at t+1, sram_wr_en_o never asserted.
REQ-033 SHALL cover: rst_ni low with 2 reads in flight -> outputs at reset values immediately; returning data never appears on down_data_o.
REQ-034 SHALL cover: random valid/ready delays 0-10 cycles, 1000 items -> scoreboard matches in order.

Source files
------------

// File: rtl/sram_fifo_pkg.sv
// sram_fifo_pkg: width helpers and output-buffer sizing
// shared by sram_fifo_ctrl and its fifo_flop output buffer.
package sram_fifo_pkg;

  localparam int OBUF_EXTRA = 1;

  function automatic int ptr_w(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  function automatic int cnt_w(input int depth, input int rd_lat);
    return $clog2(depth + rd_lat + 2);
  endfunction

  // one slot per read in flight plus one so a read can issue while the head waits
  function automatic int obuf_depth(input int rd_lat);
    return rd_lat + OBUF_EXTRA;
  endfunction

endpackage

// File: rtl/sram_fifo_ctrl_fifo_flop.sv
// fifo_flop: small flop-based circular FIFO used as the
// output buffer of sram_fifo_ctrl; push and pop may coincide.
module fifo_flop
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 3
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       push_i,
  input  logic [WIDTH-1:0]           data_i,
  input  logic                       pop_i,
  output logic                       valid_o,
  output logic [WIDTH-1:0]           data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);

  localparam int PW = ptr_w(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    head;
  logic [PW-1:0]    tail;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (cnt != '0);
  assign do_push = push_i && ((cnt != CW'(DEPTH)) || do_pop);

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push)
        tail <= (tail == PW'(DEPTH - 1)) ? '0 : tail + PW'(1);
      if (do_pop)
        head <= (head == PW'(DEPTH - 1)) ? '0 : head + PW'(1);
      cnt <= cnt + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (do_push)
      mem[tail] <= data_i;
  end

  assign valid_o = (cnt != '0);
  assign data_o  = mem[head];
  assign count_o = cnt;

endmodule

// File: rtl/sram_fifo_ctrl.sv
// sram_fifo_ctrl: valid/ready FIFO over an external SRAM with a credited
// output buffer. SRAM_FIFO_BYPASS_EN lets data skip SRAM when idle.
module sram_fifo_ctrl
  import sram_fifo_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int DEPTH  = 10,
  parameter int RD_LAT = 2
) (
  input  logic                            clk_i,
  input  logic                            rst_ni,
  input  logic                            up_valid_i,
  output logic                            up_ready_o,
  input  logic [WIDTH-1:0]                up_data_i,
  output logic                            down_valid_o,
  input  logic                            down_ready_i,
  output logic [WIDTH-1:0]                down_data_o,
  output logic                            sram_wr_en_o,
  output logic [ptr_w(DEPTH)-1:0]         sram_wr_addr_o,
  output logic [WIDTH-1:0]                sram_wr_data_o,
  output logic                            sram_rd_en_o,
  output logic [ptr_w(DEPTH)-1:0]         sram_rd_addr_o,
  input  logic [WIDTH-1:0]                sram_rd_data_i,
  output logic                            empty_o,
  output logic                            full_o,
  output logic [cnt_w(DEPTH,RD_LAT)-1:0]  count_o
);

  localparam int PW  = ptr_w(DEPTH);
  localparam int CW  = cnt_w(DEPTH, RD_LAT);
  localparam int OBD = obuf_depth(RD_LAT);
  localparam int SW  = $clog2(DEPTH + 1);
  localparam int OW  = $clog2(OBD + 1);
  localparam int FW  = $clog2(RD_LAT + 1);

  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic [SW-1:0]     socc;
  logic [RD_LAT-1:0] vld;
  logic [FW-1:0]     infl;
  logic [OW-1:0]     ocnt;
  logic              up_hs;
  logic              down_hs;
  logic              credit_ok;
  logic              byp;
  logic              wr;
  logic              rd;
  logic              push;
  logic [WIDTH-1:0]  push_data;

  assign up_ready_o = (socc < SW'(DEPTH));
  assign full_o     = ~up_ready_o;
  assign up_hs      = up_valid_i && up_ready_o;
  assign down_hs    = down_valid_o && down_ready_i;

  always_comb begin
    infl = '0;
    for (int i = 0; i < RD_LAT; i++)
      infl = infl + FW'(vld[i]);
  end

  // a slot freed by this cycle's pop may be re-credited at once
  assign credit_ok = (CW'(ocnt) + CW'(infl)) < (CW'(OBD) + CW'(down_hs));

`ifdef SRAM_FIFO_BYPASS_EN
  assign byp = up_hs && (socc == '0) && (infl == '0) && credit_ok;
`else
  assign byp = 1'b0;
`endif

  assign wr = up_hs && !byp;
  assign rd = (socc != '0) && credit_ok;

  assign push      = vld[RD_LAT-1] || byp;
  assign push_data = byp ? up_data_i : sram_rd_data_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      socc   <= '0;
      vld    <= '0;
    end else begin
      if (wr)
        wr_ptr <= (wr_ptr == PW'(DEPTH - 1)) ? '0 : wr_ptr + PW'(1);
      if (rd)
        rd_ptr <= (rd_ptr == PW'(DEPTH - 1)) ? '0 : rd_ptr + PW'(1);
      unique case ({wr, rd})
        2'b10:   socc <= socc + SW'(1);
        2'b01:   socc <= socc - SW'(1);
        default: socc <= socc;
      endcase
      vld <= RD_LAT'({vld, rd});
    end
  end

  fifo_flop #(
    .WIDTH (WIDTH),
    .DEPTH (OBD)
  ) u_obuf (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .push_i  (push),
    .data_i  (push_data),
    .pop_i   (down_ready_i),
    .valid_o (down_valid_o),
    .data_o  (down_data_o),
    .count_o (ocnt)
  );

  assign sram_wr_en_o   = wr;
  assign sram_wr_addr_o = wr_ptr;
  assign sram_wr_data_o = up_data_i;
  assign sram_rd_en_o   = rd;
  assign sram_rd_addr_o = rd_ptr;

  assign count_o = CW'(socc) + CW'(infl) + CW'(ocnt);
  assign empty_o = (count_o == '0);

endmodule

// File: tb/tb_sram_fifo_ctrl.sv
// tb_sram_fifo_ctrl: directed bench for sram_fifo_ctrl with a
// behavioural SRAM of fixed read latency and an in-order scoreboard.
module tb_sram_fifo_ctrl;

  localparam int WIDTH  = 8;
  localparam int DEPTH  = 10;
  localparam int RD_LAT = 2;
  localparam int CAP    = DEPTH + RD_LAT + 1;
`ifdef SRAM_FIFO_BYPASS_EN
  localparam int BYP = 1;
`else
  localparam int BYP = 0;
`endif
  localparam int EXP_LAT = BYP ? 1 : RD_LAT + 2;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             up_valid_i = 1'b0;
  logic             up_ready_o;
  logic [WIDTH-1:0] up_data_i = '0;
  logic             down_valid_o;
  logic             down_ready_i = 1'b0;
  logic [WIDTH-1:0] down_data_o;
  logic             sram_wr_en_o;
  logic [3:0]       sram_wr_addr_o;
  logic [WIDTH-1:0] sram_wr_data_o;
  logic             sram_rd_en_o;
  logic [3:0]       sram_rd_addr_o;
  logic [WIDTH-1:0] sram_rd_data_i;
  logic             empty_o;
  logic             full_o;
  logic [3:0]       count_o;

  sram_fifo_ctrl #(
    .WIDTH  (WIDTH),
    .DEPTH  (DEPTH),
    .RD_LAT (RD_LAT)
  ) dut (
    .clk_i          (clk_i),
    .rst_ni         (rst_ni),
    .up_valid_i     (up_valid_i),
    .up_ready_o     (up_ready_o),
    .up_data_i      (up_data_i),
    .down_valid_o   (down_valid_o),
    .down_ready_i   (down_ready_i),
    .down_data_o    (down_data_o),
    .sram_wr_en_o   (sram_wr_en_o),
    .sram_wr_addr_o (sram_wr_addr_o),
    .sram_wr_data_o (sram_wr_data_o),
    .sram_rd_en_o   (sram_rd_en_o),
    .sram_rd_addr_o (sram_rd_addr_o),
    .sram_rd_data_i (sram_rd_data_i),
    .empty_o        (empty_o),
    .full_o         (full_o),
    .count_o        (count_o)
  );

  always #5 clk_i = ~clk_i;

  // SRAM: data valid exactly RD_LAT cycles after the read enable
  logic [WIDTH-1:0] mem   [DEPTH];
  logic [WIDTH-1:0] rpipe [RD_LAT];

  always @(posedge clk_i) begin
    if (sram_wr_en_o)
      mem[int'(sram_wr_addr_o)] <= sram_wr_data_o;
    rpipe[0] <= sram_rd_en_o ? mem[int'(sram_rd_addr_o)] : 8'hEE;
    for (int i = 1; i < RD_LAT; i++)
      rpipe[i] <= rpipe[i-1];
  end

  assign sram_rd_data_i = rpipe[RD_LAT-1];

  int n_cmp = 0;
  int n_err = 0;
  logic [WIDTH-1:0] sbq [$];
  logic uhs;
  logic dhs;

  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got != exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)",
               tag, got, got, exp, exp);
    end
  endtask

  task automatic sample();
    @(negedge clk_i);
    uhs = up_valid_i && up_ready_o;
    dhs = down_valid_o && down_ready_i;
    if (uhs)
      sbq.push_back(up_data_i);
    if (dhs) begin
      if (sbq.size() == 0)
        chk("sb_underflow", 1, 0);
      else
        chk("sb_data", int'(down_data_o), int'(sbq.pop_front()));
    end
  endtask

  task automatic adv();
    @(posedge clk_i);
    #1;
  endtask

  task automatic chk_rst();
    chk("rst_down_valid", int'(down_valid_o), 0);
    chk("rst_empty", int'(empty_o), 1);
    chk("rst_full", int'(full_o), 0);
    chk("rst_up_ready", int'(up_ready_o), 1);
    chk("rst_count", int'(count_o), 0);
    chk("rst_wr_en", int'(sram_wr_en_o), 0);
    chk("rst_rd_en", int'(sram_rd_en_o), 0);
  endtask

  initial begin
    int lat;
    int acc;
    int nd;
    int nin;
    int nout;
    int first;
    int last;
    int nw;
    int nrd;
    int ghost;
    int pgap;
    int cgap;

    // reset values while held
    #1;
    chk_rst();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    adv();

    // single write latency
    up_valid_i   = 1'b1;
    up_data_i    = 8'hA5;
    down_ready_i = 1'b1;
    sample();
    chk("lat_hs", int'(uhs), 1);
    chk("lat_wr_en", int'(sram_wr_en_o), BYP ? 0 : 1);
    adv();
    up_valid_i = 1'b0;
    lat = -1;
    for (int n = 1; n <= 8; n++) begin
      sample();
      if (n == 1) begin
        chk("lat_count1", int'(count_o), 1);
        chk("lat_rd_en1", int'(sram_rd_en_o), BYP ? 0 : 1);
      end
      if (down_valid_o && lat < 0) begin
        lat = n;
        chk("lat_data", int'(down_data_o), 8'hA5);
      end
      adv();
    end
    chk("lat_cycles", lat, EXP_LAT);
    sample();
    chk("lat_empty", int'(empty_o), 1);
    adv();

    // fill with downstream stalled, then drain
    down_ready_i = 1'b0;
    up_valid_i   = 1'b1;
    acc = 0;
    up_data_i = 8'(acc);
    for (int c = 0; c < 30; c++) begin
      sample();
      if (uhs) acc++;
      adv();
      up_data_i = 8'(acc);
    end
    up_valid_i = 1'b0;
    sample();
    chk("fill_accepted", acc, CAP);
    chk("fill_count", int'(count_o), CAP);
    chk("fill_full", int'(full_o), 1);
    chk("fill_up_ready", int'(up_ready_o), 0);
    chk("fill_down_valid", int'(down_valid_o), 1);
    chk("fill_empty", int'(empty_o), 0);
    adv();
    down_ready_i = 1'b1;
    nd = 0;
    for (int c = 0; c < 40; c++) begin
      sample();
      if (dhs) nd++;
      adv();
    end
    chk("drain_n", nd, CAP);
    chk("drain_sb_left", sbq.size(), 0);
    sample();
    chk("drain_empty", int'(empty_o), 1);
    chk("drain_count", int'(count_o), 0);
    adv();

    // continuous stream of 50, one per cycle
    nin = 0;
    nout = 0;
    first = -1;
    last = -1;
    up_valid_i = 1'b1;
    up_data_i  = 8'(nin);
    for (int c = 0; c < 200 && nout < 50; c++) begin
      sample();
      if (uhs) nin++;
      if (dhs) begin
        if (first < 0) first = c;
        last = c;
        nout++;
      end
      adv();
      up_valid_i = (nin < 50);
      up_data_i  = 8'(nin);
    end
    up_valid_i = 1'b0;
    chk("strm_n", nout, 50);
    chk("strm_rate", last - first, 49);
    chk("strm_first", first, EXP_LAT);

    // reset with two reads in flight
    down_ready_i = 1'b0;
    up_valid_i   = 1'b1;
    nw = 0;
    nrd = 0;
    up_data_i = 8'h70;
    for (int c = 0; c < 20 && nrd < 2; c++) begin
      sample();
      if (uhs) nw++;
      if (sram_rd_en_o) nrd++;
      adv();
      up_data_i  = 8'h70 + 8'(nw);
      up_valid_i = (nw < 4);
    end
    chk("mid_rd2", nrd, 2);
    #1;
    up_valid_i = 1'b0;
    rst_ni = 1'b0;
    #1;
    chk_rst();
    sbq.delete();
    repeat (4) @(negedge clk_i);
    rst_ni = 1'b1;
    adv();
    down_ready_i = 1'b1;
    ghost = 0;
    for (int c = 0; c < 10; c++) begin
      sample();
      if (down_valid_o) ghost++;
      adv();
    end
    chk("mid_ghost", ghost, 0);
    chk("mid_count", int'(count_o), 0);

    // random delays on both sides, 1000 items
    nin = 0;
    nout = 0;
    pgap = 0;
    cgap = 0;
    up_valid_i   = 1'b1;
    up_data_i    = 8'(nin);
    down_ready_i = 1'b1;
    for (int c = 0; c < 20000 && nout < 1000; c++) begin
      sample();
      if (uhs) begin
        nin++;
        pgap = int'($urandom_range(0, 10));
      end else if (pgap > 0) begin
        pgap--;
      end
      if (dhs) begin
        nout++;
        cgap = int'($urandom_range(0, 10));
      end else if (cgap > 0) begin
        cgap--;
      end
      adv();
      up_valid_i   = (pgap == 0) && (nin < 1000);
      up_data_i    = 8'(nin);
      down_ready_i = (cgap == 0);
    end
    up_valid_i = 1'b0;
    chk("rnd_n", nout, 1000);
    chk("rnd_sb_left", sbq.size(), 0);
    sample();
    chk("rnd_empty", int'(empty_o), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
